// File: rtl/seg7_symbol_sequencer.sv
// Steps symbol codes 0..NUM_SYMBOLS-1 out to the seg7 decoder, each held for a dwell
// with an optional blank gap between. Define SEG7_SEQ_LOOP_EN to repeat passes until stop.
module seg7_symbol_sequencer #(
   parameter int TICKS_PER_STEP = 10_000_000,
   parameter int GAP_TICKS      = 0,
   parameter int NUM_SYMBOLS    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       busy,
   output logic       done
);

   localparam int TMAX = (TICKS_PER_STEP > GAP_TICKS) ? TICKS_PER_STEP : GAP_TICKS;
   localparam int CMAX = (TMAX > 2) ? TMAX : 2;
   localparam int CW   = $clog2(CMAX);

   localparam logic [CW-1:0] STEP_LAST = CW'(TICKS_PER_STEP - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
   localparam logic [3:0]    LAST_IDX  = 4'(NUM_SYMBOLS - 1);
   localparam logic [3:0]    BLANK     = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    idx, idx_n;
   logic [3:0]    digit_n;
   logic          valid_n, busy_n, done_n;
   logic          go_idle, pass_end;

   // Next-state and next-output logic; every output is registered so it follows its cause by one edge.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      digit_n  = digit;
      valid_n  = digit_valid;
      busy_n   = busy;
      done_n   = 1'b0;
      go_idle  = 1'b0;
      pass_end = 1'b0;

      case (state)
         IDLE: begin
            // a start raised during the done cycle is deliberately not taken
            if (start && !stop && !done) begin
               state_n = SHOW;
               idx_n   = 4'd0;
               cnt_n   = '0;
               digit_n = 4'd0;
               valid_n = 1'b1;
               busy_n  = 1'b1;
            end
         end
         SHOW: begin
            if (stop) begin
               go_idle = 1'b1;
            end else if (!pause) begin
               if (cnt == STEP_LAST) begin
                  cnt_n = '0;
                  if (GAP_TICKS > 0) begin
                     state_n = GAP;
                     digit_n = BLANK;
                     valid_n = 1'b0;
                  end else if (idx < LAST_IDX) begin
                     idx_n   = idx + 4'd1;
                     digit_n = idx + 4'd1;
                  end else begin
                     pass_end = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         GAP: begin
            if (stop) begin
               go_idle = 1'b1;
            end else if (!pause) begin
               if (cnt == GAP_LAST) begin
                  cnt_n = '0;
                  if (idx < LAST_IDX) begin
                     state_n = SHOW;
                     idx_n   = idx + 4'd1;
                     digit_n = idx + 4'd1;
                     valid_n = 1'b1;
                  end else begin
                     pass_end = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (go_idle) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = 4'd0;
         digit_n = BLANK;
         valid_n = 1'b0;
         busy_n  = 1'b0;
      end else if (pass_end) begin
         done_n = 1'b1;
         cnt_n  = '0;
         idx_n  = 4'd0;
`ifdef SEG7_SEQ_LOOP_EN
         state_n = SHOW;
         digit_n = 4'd0;
         valid_n = 1'b1;
         busy_n  = 1'b1;
`else
         state_n = IDLE;
         digit_n = BLANK;
         valid_n = 1'b0;
         busy_n  = 1'b0;
`endif
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 4'd0;
         digit       <= BLANK;
         digit_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         digit       <= digit_n;
         digit_valid <= valid_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

endmodule

// File: tb/tb_seg7_symbol_sequencer.sv
// Scoreboard bench for seg7_symbol_sequencer: three parameterisations share one stimulus stream,
// expected frames come from a timeline model and are checked by an independent monitor.
module tb_seg7_symbol_sequencer;

   typedef struct packed {
      logic [3:0] digit;
      logic       valid;
      logic       busy;
      logic       done;
   } frame_t;

   localparam frame_t IDLE_F = '{digit: 4'hF, valid: 1'b0, busy: 1'b0, done: 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic pause = 1'b0;
   logic stop = 1'b0;

   logic [3:0] dg [3];
   logic       dv [3];
   logic       by [3];
   logic       dn [3];

   frame_t exp0[$];
   frame_t exp1[$];
   frame_t exp2[$];

   int     act [3];
   int     pos [3];
   frame_t last [3];

   int tests = 0;
   int fails = 0;
   int cycleNo = 0;

   always #5 clk = ~clk;

   seg7_symbol_sequencer #(.TICKS_PER_STEP(4), .GAP_TICKS(2), .NUM_SYMBOLS(6)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .digit(dg[0]), .digit_valid(dv[0]), .busy(by[0]), .done(dn[0]));

   seg7_symbol_sequencer #(.TICKS_PER_STEP(4), .GAP_TICKS(0), .NUM_SYMBOLS(6)) dut1 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .digit(dg[1]), .digit_valid(dv[1]), .busy(by[1]), .done(dn[1]));

   seg7_symbol_sequencer #(.TICKS_PER_STEP(3), .GAP_TICKS(1), .NUM_SYMBOLS(1)) dut2 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .digit(dg[2]), .digit_valid(dv[2]), .busy(by[2]), .done(dn[2]));

   function automatic int cfgT(int i);
      return (i == 2) ? 3 : 4;
   endfunction

   function automatic int cfgG(int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 1);
   endfunction

   function automatic int cfgN(int i);
      return (i == 2) ? 1 : 6;
   endfunction

   // What the display shows at position p of a pass: symbol p/(T+G) for T ticks, then blank for G ticks.
   function automatic frame_t passFrame(int i, int p);
      frame_t f;
      int period = cfgT(i) + cfgG(i);
      int sym = p / period;
      if ((p % period) < cfgT(i)) begin
         f.digit = 4'(sym);
         f.valid = 1'b1;
      end else begin
         f.digit = 4'hF;
         f.valid = 1'b0;
      end
      f.busy = 1'b1;
      f.done = 1'b0;
      return f;
   endfunction

   function automatic void pushExp(int i, frame_t f);
      if (i == 0) exp0.push_back(f);
      else if (i == 1) exp1.push_back(f);
      else exp2.push_back(f);
   endfunction

   // Predicts the outputs after the coming edge from the inputs now being applied.
   function automatic void modelEdge(int i);
      frame_t f;
      int len = cfgN(i) * (cfgT(i) + cfgG(i));
      if (rst) begin
         act[i] = 0;
         f = IDLE_F;
      end else if (act[i] == 0) begin
         if (start && !stop && !last[i].done) begin
            act[i] = 1;
            pos[i] = 0;
            f = passFrame(i, 0);
         end else begin
            f = IDLE_F;
         end
      end else if (stop) begin
         act[i] = 0;
         f = IDLE_F;
      end else if (pause) begin
         f = last[i];
         f.done = 1'b0;
      end else if (pos[i] == len - 1) begin
`ifdef SEG7_SEQ_LOOP_EN
         pos[i] = 0;
         f = passFrame(i, 0);
`else
         act[i] = 0;
         f = IDLE_F;
`endif
         f.done = 1'b1;
      end else begin
         pos[i] = pos[i] + 1;
         f = passFrame(i, pos[i]);
      end
      last[i] = f;
      pushExp(i, f);
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic st, input logic pz);
      rst = r;
      start = s;
      stop = st;
      pause = pz;
      for (int i = 0; i < 3; i++) modelEdge(i);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int i, input frame_t expv);
      frame_t got;
      got = '{digit: dg[i], valid: dv[i], busy: by[i], done: dn[i]};
      tests++;
      if (got !== expv) begin
         fails++;
         $display("[TB] FAIL inst%0d cycle %0d: got digit=%h valid=%b busy=%b done=%b, expected digit=%h valid=%b busy=%b done=%b",
                  i, cycleNo, got.digit, got.valid, got.busy, got.done,
                  expv.digit, expv.valid, expv.busy, expv.done);
      end
   endtask

   // Monitor: one expected frame per edge per instance, compared on the falling edge.
   always @(negedge clk) begin
      cycleNo++;
      if (exp0.size() > 0) checkOutput(0, exp0.pop_front());
      if (exp1.size() > 0) checkOutput(1, exp1.pop_front());
      if (exp2.size() > 0) checkOutput(2, exp2.pop_front());
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         act[i] = 0;
         pos[i] = 0;
         last[i] = IDLE_F;
      end

      // reset held two cycles with start asserted
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);

      // plain pass
      applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 45; c++) applyStimulus(0, 0, 0, 0);

      // pass with pause for three cycles while digit 2 is shown
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 50; c++) applyStimulus(0, 0, 0, (c >= 12 && c < 15));

      // stop while digit 3 is shown, then start and stop together in idle
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 19; c++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0);

      // reset in the middle of a pass
      applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 5) == 0);
      end

      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
